// File: rtl/result_uart_tx.sv
// Reads result RAM words 0..last_addr and serialises each one over a UART TX line (8N1).
// Define RESULT_UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module result_uart_tx #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] last_addr,
    input  logic                 abort,
    output logic [ADDR_BITS-1:0] ram_rdaddr,
    input  logic [DATA_BITS-1:0] ram_q,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int CPB_RAW      = CLK_HZ / BAUD;
    localparam int CLKS_PER_BIT = (CPB_RAW < 2) ? 2 : CPB_RAW;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int BIT_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   abort_flag;
    logic [ADDR_BITS-1:0]   last_q;
    logic [DATA_BITS-1:0]   shreg;
    logic                   baud_last;

`ifdef RESULT_UART_PARITY_EN
    logic                   par_bit;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
        return ^word;
    endfunction
`endif

    assign baud_last = (baud_cnt == CNT_LAST);

    // Payload path: no reset needed, every value is loaded before it is used.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            last_q <= last_addr;
        end
        if (state == LATCH) begin
            shreg <= ram_q;
`ifdef RESULT_UART_PARITY_EN
            par_bit <= even_parity(ram_q);
`endif
        end else if ((state == START || state == DATA) && baud_last) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            ram_rdaddr <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            abort_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                abort_flag <= 1'b1;
            end

            case (state)
                IDLE: begin
                    tx         <= 1'b1;
                    busy       <= 1'b0;
                    abort_flag <= 1'b0;
                    baud_cnt   <= '0;
                    bit_cnt    <= '0;
                    if (start) begin
                        ram_rdaddr <= '0;
                        busy       <= 1'b1;
                        state      <= FETCH;
                    end
                end

                FETCH: begin
                    tx    <= 1'b1;
                    state <= LATCH;
                end

                LATCH: begin
                    tx       <= 1'b0;
                    baud_cnt <= '0;
                    state    <= START;
                end

                START: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
`ifdef RESULT_UART_PARITY_EN
                            tx    <= par_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            tx      <= shreg[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (baud_last) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    tx <= 1'b1;
                    // done is raised one cycle early so it coincides with the final stop cycle.
                    if (baud_cnt == CNT_PRE && !abort_flag && !abort && ram_rdaddr == last_q) begin
                        done <= 1'b1;
                    end
                    if (baud_last) begin
                        baud_cnt <= '0;
                        if (abort_flag || ram_rdaddr == last_q) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            ram_rdaddr <= ram_rdaddr + ADDR_BITS'(1);
                            state      <= FETCH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Reads filtered results back out of the result RAM, which the rank-order filter path fills, and serialises each word over a UART TX line (8N1 by default).
- It is the reader/exporter counterpart to the RAM writer. It drives the RAM read-address port and owns it while busy.
- A single start pulse dumps addresses 0..last_addr in order, then the block returns to idle.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. CLKS_PER_BIT = CLK_HZ/BAUD, integer division, minimum 2.
- DATA_BITS, 8, RAM word width, which is also the UART payload width.
- ADDR_BITS, 8, RAM address width.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request pulse; sampled only in IDLE.
- last_addr  input  ADDR_BITS  final address to send; latched on accepted start.
- abort  input  1  synchronous cancel; the current frame finishes, then the block goes to IDLE.
- ram_rdaddr  output  ADDR_BITS  RAM read address.
- ram_q  input  DATA_BITS  RAM read data; registered RAM, valid 1 cycle after ram_rdaddr.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from accepted start until return to IDLE.
- done  output  1  one-cycle pulse on normal completion (not after abort).

Behaviour:
- Reset (async, rst=0): tx=1, busy=0, done=0, ram_rdaddr=0, state=IDLE, baud counter=0, bit counter=0, abort flag cleared.
- States: IDLE, FETCH, LATCH, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE:
  - tx=1, busy=0.
  - start=1: latch last_addr, ram_rdaddr<=0, busy<=1, go to FETCH.
  - start while busy is ignored; no queueing.
- FETCH: one cycle; RAM registers the address. tx=1.
- LATCH: shift register <= ram_q, go to START. tx=1.
- START: tx=0 for exactly CLKS_PER_BIT cycles.
- DATA:
  - DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit counter counts 0..DATA_BITS-1.
- STOP: tx=1 for CLKS_PER_BIT cycles. On its last cycle:
  - abort flag set: go to IDLE, busy<=0, no done.
  - else ram_rdaddr==latched last_addr: go to IDLE, busy<=0, done=1 for one cycle.
  - else ram_rdaddr<=ram_rdaddr+1, go to FETCH.
- Timing:
  - Frame spacing: 2 idle-high cycles (FETCH, LATCH) between consecutive STOP and START.
  - Clocks per word = 2 + (DATA_BITS+2)*CLKS_PER_BIT.
  - First falling edge of tx occurs 3 cycles after the start cycle.
- Address range and wrap-around:
  - last_addr=0 sends exactly one word.
  - last_addr=2^ADDR_BITS-1 sends all words; ram_rdaddr never wraps, because it stops at last_addr.
- abort:
  - Sets a sticky flag when it arrives in any non-IDLE state.
  - Takes effect only at the end of STOP, so a frame is never truncated on the line.
  - abort in IDLE is ignored.
  - start and abort in the same IDLE cycle: start is accepted, abort is ignored.
- Mid-frame async reset: tx goes high immediately and all state clears. The receiver sees a framing error at most.
- Baud counter: counts 0..CLKS_PER_BIT-1 and advances the bit/state on terminal count. It restarts at 0 on each state entry.
- ram_rdaddr is stable from FETCH through STOP of each word.

Optional Feature:
- Macro: RESULT_UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It sends the even-parity bit (XOR of payload) for CLKS_PER_BIT cycles.
  - Clocks per word = 2 + (DATA_BITS+3)*CLKS_PER_BIT.
- Undefined: no PARITY state; 8N1 framing as above.

Test Plan:
- CLK_HZ=1000, BAUD=100 (10 clocks/bit); RAM[0]=0xA5, last_addr=0, pulse start.
  - tx low 3 cycles later for 10 cycles.
  - Then bits 1,0,1,0,0,1,0,1, then high.
  - done pulses once, 2+100=102 cycles after start; busy low after.
- RAM[0..2]=0x01,0x80,0xFF, last_addr=2.
  - Three frames, each 100 cycles, separated by exactly 2 high cycles.
  - ram_rdaddr steps 0,1,2; a single done pulse.
- start pulsed again mid-transfer: ignored, no restart, word count unchanged.
- abort asserted during DATA of word 1 with last_addr=5.
  - Word 1 completes with full stop bit, then IDLE.
  - busy falls, no done pulse, ram_rdaddr=1.
- rst pulled low during DATA: tx=1 and busy=0 immediately.
  - After release, start with last_addr=0 sends RAM[0] correctly.
- With RESULT_UART_PARITY_EN, RAM[0]=0x07: parity bit 1 after the data bits; frame 110 cycles; done 112 cycles after start.
